// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the 5-stage pipeline. A three-slot
// scoreboard (EX, MEM, WB) mirrors the instructions in flight. From it the
// block derives stall/flush/freeze control, EX operand forwarding selects,
// the WB->ID bypass and a saturating stall-cycle counter.
//
// Optional feature macro: HAZARD_FWD_EN
//   defined   : EX operand forwarding and WB->ID bypass are active; only a
//               load followed by a dependent instruction stalls.
//   undefined : forwarding/bypass outputs are tied low; any in-flight
//               producer of a used ID source stalls decode.
//
// Memory handshake: mem_ready_i is a completion strobe for the access held
// in the MEM slot. While the MEM slot holds a LOAD/STORE and mem_ready_i is
// low, the whole pipeline freezes; the cycle mem_ready_i is high the access
// completes and the pipeline advances on that clock edge.
//
// dbg_state_o exposes the FSM state (0 = RUN, 1 = MEM_WAIT).
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       id_rd_i,
   input  logic             id_reg_write_i,
   input  logic             id_mem_read_i,
   input  logic             id_mem_op_i,
   input  logic             ex_branch_taken_i,
   input  logic             mem_ready_i,
   output logic             stall_o,
   output logic             flush_id_o,
   output logic             flush_ex_o,
   output logic             freeze_o,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic             wb_byp1_o,
   output logic             wb_byp2_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             dbg_state_o
);

   // FSM encoding
   localparam logic ST_RUN      = 1'b0;
   localparam logic ST_MEM_WAIT = 1'b1;

   // One scoreboard entry
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
      logic       mem_op;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use_rs1;
      logic       use_rs2;
   } slot_t;

   localparam slot_t BUBBLE = '0;

   slot_t            ex_q;
   slot_t            mem_q;
   slot_t            wb_q;
   slot_t            id_slot;
   slot_t            ex_d;
   logic             state_q;
   logic             state_d;
   logic [CNT_W-1:0] stall_cnt_q;

   logic             freeze_cond;
   logic             hazard;
   logic             branch_act;
   logic             stall_int;
   logic             flush_ex_int;
   logic             id_src1;
   logic             id_src2;

   // A slot produces a value only if it really writes a non-zero register
   function automatic logic is_producer(input slot_t s);
      return s.valid && s.reg_write && (s.rd != 5'd0);
   endfunction

   // Producer s writes the register a used source wants
   function automatic logic src_hit(input slot_t s, input logic [4:0] rs,
                                    input logic use_src);
      return use_src && is_producer(s) && (s.rd == rs);
   endfunction

`ifdef HAZARD_FWD_EN
   // Operand source for an EX operand: MEM result first, then WB data
   function automatic logic [1:0] fwd_sel(input slot_t m, input slot_t w,
                                          input logic [4:0] rs,
                                          input logic use_src);
      logic [1:0] sel;
      sel = 2'b00;
      if (src_hit(m, rs, use_src) && !m.mem_read) begin
         sel = 2'b01;
      end else if (src_hit(w, rs, use_src)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction
`endif

   // Package the decode instruction as a would-be EX slot entry
   always_comb begin
      id_slot           = BUBBLE;
      id_slot.valid     = id_valid_i;
      id_slot.rd        = id_rd_i;
      id_slot.reg_write = id_reg_write_i;
      id_slot.mem_read  = id_mem_read_i;
      id_slot.mem_op    = id_mem_op_i;
      id_slot.rs1       = id_rs1_i;
      id_slot.rs2       = id_rs2_i;
      id_slot.use_rs1   = id_use_rs1_i;
      id_slot.use_rs2   = id_use_rs2_i;
   end

   // Memory wait condition and decode data hazard detection
   always_comb begin
      freeze_cond = mem_q.valid && mem_q.mem_op && !mem_ready_i;
      // Sources of a non-instruction never need a value
      id_src1 = id_valid_i && id_use_rs1_i;
      id_src2 = id_valid_i && id_use_rs2_i;
`ifdef HAZARD_FWD_EN
      // Only a load in EX cannot be forwarded in time
      hazard = ex_q.mem_read &&
               (src_hit(ex_q, id_rs1_i, id_src1) ||
                src_hit(ex_q, id_rs2_i, id_src2));
`else
      // Without forwarding every in-flight producer blocks decode
      hazard = src_hit(ex_q,  id_rs1_i, id_src1) ||
               src_hit(ex_q,  id_rs2_i, id_src2) ||
               src_hit(mem_q, id_rs1_i, id_src1) ||
               src_hit(mem_q, id_rs2_i, id_src2) ||
               src_hit(wb_q,  id_rs1_i, id_src1) ||
               src_hit(wb_q,  id_rs2_i, id_src2);
`endif
   end

   // Priority: freeze over branch flush over hazard stall
   always_comb begin
      branch_act   = !freeze_cond && ex_branch_taken_i;
      stall_int    = !freeze_cond && !ex_branch_taken_i && hazard;
      flush_ex_int = branch_act || stall_int;
   end

   // Drive control outputs; all forced low while reset is asserted
   always_comb begin
      freeze_o   = !rst_i && freeze_cond;
      stall_o    = !rst_i && stall_int;
      flush_id_o = !rst_i && branch_act;
      flush_ex_o = !rst_i && flush_ex_int;
   end

   // Forwarding selects and WB->ID bypass
   always_comb begin
      fwd_a_o   = 2'b00;
      fwd_b_o   = 2'b00;
      wb_byp1_o = 1'b0;
      wb_byp2_o = 1'b0;
`ifdef HAZARD_FWD_EN
      if (!rst_i) begin
         fwd_a_o   = fwd_sel(mem_q, wb_q, ex_q.rs1, ex_q.use_rs1);
         fwd_b_o   = fwd_sel(mem_q, wb_q, ex_q.rs2, ex_q.use_rs2);
         wb_byp1_o = src_hit(wb_q, id_rs1_i, id_use_rs1_i);
         wb_byp2_o = src_hit(wb_q, id_rs2_i, id_use_rs2_i);
      end
`endif
   end

   // Next EX entry: bubble when decode is stalled, flushed or empty
   always_comb begin
      ex_d = id_slot;
      if (flush_ex_int || !id_valid_i) begin
         ex_d = BUBBLE;
      end
   end

   // FSM next state: wait in MEM_WAIT until the access completes
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (freeze_cond) begin
               state_d = ST_MEM_WAIT;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready_i) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Scoreboard advance; every slot holds while frozen
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_q  <= BUBBLE;
         mem_q <= BUBBLE;
         wb_q  <= BUBBLE;
      end else if (!freeze_cond) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= ex_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Saturating count of stalled or frozen cycles
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else if ((stall_int || freeze_cond) &&
                   (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign dbg_state_o = state_q;

   // WB entry fields that nothing downstream needs
   logic unused_wb;
   assign unused_wb = ^{wb_q.mem_read, wb_q.mem_op, wb_q.rs1, wb_q.rs2,
                        wb_q.use_rs1, wb_q.use_rs2};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios with fixed
// expectations plus randomized traffic against a pipeline reference model.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic [4:0]  id_rd;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        id_mem_op;
   logic        br;
   logic        mem_ready;
   logic        stall_o;
   logic        flush_id_o;
   logic        flush_ex_o;
   logic        freeze_o;
   logic [1:0]  fwd_a_o;
   logic [1:0]  fwd_b_o;
   logic        wb_byp1_o;
   logic        wb_byp2_o;
   logic [31:0] stall_cnt_o;
   logic        dbg_state_o;

   int checks = 0;
   int errors = 0;

   pipeline_hazard_ctrl #(.CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
      .id_rd_i(id_rd), .id_reg_write_i(id_reg_write),
      .id_mem_read_i(id_mem_read), .id_mem_op_i(id_mem_op),
      .ex_branch_taken_i(br), .mem_ready_i(mem_ready),
      .stall_o(stall_o), .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o),
      .freeze_o(freeze_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
      .wb_byp1_o(wb_byp1_o), .wb_byp2_o(wb_byp2_o),
      .stall_cnt_o(stall_cnt_o), .dbg_state_o(dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic v; logic [4:0] rd; logic rw; logic mr; logic mo;
      logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
   } instr_t;

   typedef struct packed {
      logic frz; logic stl; logic fid; logic fex;
      logic [1:0] fa; logic [1:0] fb; logic b1; logic b2;
   } ctrl_t;

   instr_t pipe_q[$];   // [0] in EX, [1] in MEM, [2] in WB
   longint exp_cnt;
   bit     exp_wait;

   function automatic bit writes(instr_t s, logic [4:0] r);
      return s.v && s.rw && (s.rd != 5'd0) && (s.rd == r);
   endfunction

   // Where an EX operand gets its value from
   function automatic logic [1:0] src_of(instr_t m, instr_t w, logic [4:0] r, logic u);
      if (!FWD_EN || !u) return 2'd0;
      if (writes(m, r) && !m.mr) return 2'd1;
      if (writes(w, r)) return 2'd2;
      return 2'd0;
   endfunction

   // Decode must wait if the value of r is not reachable this cycle
   function automatic bit must_wait(logic [4:0] r, logic u);
      if (!u) return 1'b0;
      for (int k = 0; k < 3; k++)
         if (writes(pipe_q[k], r) && (!FWD_EN || (k == 0 && pipe_q[k].mr))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic ctrl_t model_ctrl();
      ctrl_t c;
      bit hz;
      c = '0;
      c.frz = pipe_q[1].v && pipe_q[1].mo && !mem_ready;
      hz = id_valid && (must_wait(id_rs1, id_use_rs1) || must_wait(id_rs2, id_use_rs2));
      if (!c.frz && br) begin
         c.fid = 1'b1; c.fex = 1'b1;
      end else if (!c.frz && hz) begin
         c.stl = 1'b1; c.fex = 1'b1;
      end
      c.fa = src_of(pipe_q[1], pipe_q[2], pipe_q[0].rs1, pipe_q[0].v && pipe_q[0].u1);
      c.fb = src_of(pipe_q[1], pipe_q[2], pipe_q[0].rs2, pipe_q[0].v && pipe_q[0].u2);
      c.b1 = FWD_EN && id_use_rs1 && writes(pipe_q[2], id_rs1);
      c.b2 = FWD_EN && id_use_rs2 && writes(pipe_q[2], id_rs2);
      return c;
   endfunction

   task automatic model_reset();
      pipe_q = {instr_t'(0), instr_t'(0), instr_t'(0)};
      exp_cnt = 0;
      exp_wait = 1'b0;
   endtask

   task automatic model_advance();
      ctrl_t c;
      instr_t nxt;
      c = model_ctrl();
      if ((c.stl || c.frz) && exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
      exp_wait = c.frz;
      if (!c.frz) begin
         nxt = '0;
         if (id_valid && !c.fex) begin
            nxt.v = 1'b1; nxt.rd = id_rd; nxt.rw = id_reg_write;
            nxt.mr = id_mem_read; nxt.mo = id_mem_op;
            nxt.rs1 = id_rs1; nxt.rs2 = id_rs2;
            nxt.u1 = id_use_rs1; nxt.u2 = id_use_rs2;
         end
         pipe_q.push_front(nxt);
         void'(pipe_q.pop_back());
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_id(input bit v, input logic [4:0] rd, input bit rw,
                           input bit mr, input bit mo,
                           input logic [4:0] r1, input bit u1,
                           input logic [4:0] r2, input bit u2);
      id_valid = v; id_rd = rd; id_reg_write = rw;
      id_mem_read = mr; id_mem_op = mo;
      id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
   endtask

   task automatic idle_id();
      drive_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   // Clock edge; the model advances with the inputs the DUT sampled
   task automatic tick();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; br = 1'b0; mem_ready = 1'b1;
      idle_id();
      #7;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; br = 1'b1; mem_ready = 1'b0;
      drive_id(1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1);
      #12;
      checks++;
      if ({stall_o, flush_id_o, flush_ex_o, freeze_o, fwd_a_o, fwd_b_o,
           wb_byp1_o, wb_byp2_o, dbg_state_o} !== 11'd0) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 0", {stall_o, flush_id_o, flush_ex_o,
                  freeze_o, fwd_a_o, fwd_b_o, wb_byp1_o, wb_byp2_o, dbg_state_o});
      end
      checks++;
      if (stall_cnt_o !== 32'd0) begin
         errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt_o);
      end
      do_reset();
   endtask

   // lw x5 ; add x6,x5,x1
   task automatic test_load_use();
      int n_stall;
      n_stall = FWD_EN ? 1 : 3;
      do_reset();
      drive_id(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_pre_stall got %b exp 0", stall_o); end
      tick();
      drive_id(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1);
      for (int k = 0; k < n_stall; k++) begin
         @(negedge clk);
         checks++;
         if ({stall_o, flush_ex_o, flush_id_o} !== 3'b110) begin
            errors++; $display("FAIL lu_stall[%0d] got %b exp 110", k, {stall_o, flush_ex_o, flush_id_o});
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", stall_o); end
      tick();
      idle_id();
      @(negedge clk);
      checks++;
      if (fwd_a_o !== (FWD_EN ? 2'b10 : 2'b00) || fwd_b_o !== 2'b00) begin
         errors++; $display("FAIL lu_fwd got %b/%b exp %b/00", fwd_a_o, fwd_b_o, FWD_EN ? 2'b10 : 2'b00);
      end
      checks++;
      if (stall_cnt_o !== 32'(n_stall)) begin
         errors++; $display("FAIL lu_cnt got %0d exp %0d", stall_cnt_o, n_stall);
      end
      tick();
   endtask

   // add x5 ; sub x7,x5,x5
   task automatic test_alu_fwd();
      int n_stall;
      n_stall = FWD_EN ? 0 : 3;
      do_reset();
      drive_id(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
      tick();
      drive_id(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1);
      for (int k = 0; k < n_stall; k++) begin
         @(negedge clk);
         checks++;
         if (stall_o !== 1'b1) begin errors++; $display("FAIL alu_stall[%0d] got %b exp 1", k, stall_o); end
         tick();
      end
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_nostall got %b exp 0", stall_o); end
      tick();
      idle_id();
      @(negedge clk);
      checks++;
      if (fwd_a_o !== (FWD_EN ? 2'b01 : 2'b00) || fwd_b_o !== (FWD_EN ? 2'b01 : 2'b00)) begin
         errors++; $display("FAIL alu_fwd got %b/%b exp %b", fwd_a_o, fwd_b_o, FWD_EN ? 2'b01 : 2'b00);
      end
      checks++;
      if (stall_cnt_o !== 32'(n_stall)) begin
         errors++; $display("FAIL alu_cnt got %0d exp %0d", stall_cnt_o, n_stall);
      end
      tick();
   endtask

   // add x9 ; lw x5 ; bubble, then memory not ready for 3 cycles
   task automatic test_mem_wait();
      do_reset();
      drive_id(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      drive_id(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      idle_id();
      tick();
      mem_ready = 1'b0;
      drive_id(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({freeze_o, stall_o, flush_ex_o, dbg_state_o} !== {1'b1, 1'b0, 1'b0, k > 0}) begin
            errors++; $display("FAIL mw_freeze[%0d] got %b exp %b", k,
                               {freeze_o, stall_o, flush_ex_o, dbg_state_o}, {1'b1, 1'b0, 1'b0, k > 0});
         end
         checks++;
         if (wb_byp1_o !== FWD_EN) begin
            errors++; $display("FAIL mw_hold_wb[%0d] got %b exp %b", k, wb_byp1_o, FWD_EN);
         end
         tick();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({freeze_o, dbg_state_o, stall_o} !== {1'b0, 1'b1, !FWD_EN}) begin
         errors++; $display("FAIL mw_ready got %b exp %b", {freeze_o, dbg_state_o, stall_o}, {1'b0, 1'b1, !FWD_EN});
      end
      checks++;
      if (stall_cnt_o !== 32'd3) begin errors++; $display("FAIL mw_cnt got %0d exp 3", stall_cnt_o); end
      tick();
      @(negedge clk);
      checks++;
      if ({dbg_state_o, stall_o} !== 2'b00) begin
         errors++; $display("FAIL mw_run got %b exp 00", {dbg_state_o, stall_o});
      end
      idle_id();
      tick();
   endtask

   // lw x5 in EX, lw x6,x5 in ID, branch taken
   task automatic test_branch();
      do_reset();
      drive_id(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      drive_id(1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
      br = 1'b1;
      @(negedge clk);
      checks++;
      if ({flush_id_o, flush_ex_o, stall_o} !== 3'b110) begin
         errors++; $display("FAIL br_flush got %b exp 110", {flush_id_o, flush_ex_o, stall_o});
      end
      tick();
      br = 1'b0;
      drive_id(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if ({stall_o, flush_ex_o, flush_id_o} !== 3'b000) begin
         errors++; $display("FAIL br_bubble got %b exp 000", {stall_o, flush_ex_o, flush_id_o});
      end
      idle_id();
      tick();
   endtask

   // add x0 ; add x6,x0,x0
   task automatic test_x0();
      do_reset();
      drive_id(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
      tick();
      drive_id(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({stall_o, wb_byp1_o, wb_byp2_o} !== 3'b000) begin
            errors++; $display("FAIL x0_nohaz[%0d] got %b exp 000", k, {stall_o, wb_byp1_o, wb_byp2_o});
         end
         tick();
      end
      idle_id();
      @(negedge clk);
      checks++;
      if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin
         errors++; $display("FAIL x0_fwd got %b exp 0000", {fwd_a_o, fwd_b_o});
      end
      tick();
   endtask

   // Reset asserted while waiting on memory
   task automatic test_reset_mid_freeze();
      do_reset();
      drive_id(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      idle_id();
      tick();
      mem_ready = 1'b0;
      br = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if ({freeze_o, dbg_state_o, flush_id_o} !== 3'b110) begin
         errors++; $display("FAIL rmf_wait got %b exp 110", {freeze_o, dbg_state_o, flush_id_o});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({freeze_o, dbg_state_o, flush_id_o, flush_ex_o, stall_o} !== 5'b00000 || stall_cnt_o !== 32'd0) begin
         errors++; $display("FAIL rmf_clear got %b cnt %0d exp 00000 cnt 0",
                            {freeze_o, dbg_state_o, flush_id_o, flush_ex_o, stall_o}, stall_cnt_o);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      br = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if ({freeze_o, dbg_state_o} !== 2'b00) begin
         errors++; $display("FAIL rmf_after got %b exp 00", {freeze_o, dbg_state_o});
      end
      mem_ready = 1'b1;
      tick();
   endtask

   // Random traffic checked every cycle against the model
   task automatic test_random();
      ctrl_t c;
      bit hold;
      int kind;
      do_reset();
      hold = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!hold) begin
            kind = $urandom_range(0, 9);
            drive_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)),
                     kind < 5 ? (kind < 3) : ($urandom_range(0, 4) != 0),
                     kind < 3, kind < 5,
                     5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            br = ($urandom_range(0, 9) == 0);
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         c = model_ctrl();
         checks++; if (freeze_o !== c.frz) begin errors++; $display("FAIL rnd_freeze cyc %0d got %b exp %b", cyc, freeze_o, c.frz); end
         checks++; if (stall_o !== c.stl) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", cyc, stall_o, c.stl); end
         checks++; if (flush_id_o !== c.fid) begin errors++; $display("FAIL rnd_flush_id cyc %0d got %b exp %b", cyc, flush_id_o, c.fid); end
         checks++; if (flush_ex_o !== c.fex) begin errors++; $display("FAIL rnd_flush_ex cyc %0d got %b exp %b", cyc, flush_ex_o, c.fex); end
         checks++; if (fwd_a_o !== c.fa) begin errors++; $display("FAIL rnd_fwd_a cyc %0d got %b exp %b", cyc, fwd_a_o, c.fa); end
         checks++; if (fwd_b_o !== c.fb) begin errors++; $display("FAIL rnd_fwd_b cyc %0d got %b exp %b", cyc, fwd_b_o, c.fb); end
         checks++; if (wb_byp1_o !== c.b1) begin errors++; $display("FAIL rnd_byp1 cyc %0d got %b exp %b", cyc, wb_byp1_o, c.b1); end
         checks++; if (wb_byp2_o !== c.b2) begin errors++; $display("FAIL rnd_byp2 cyc %0d got %b exp %b", cyc, wb_byp2_o, c.b2); end
         checks++; if (dbg_state_o !== exp_wait) begin errors++; $display("FAIL rnd_state cyc %0d got %b exp %b", cyc, dbg_state_o, exp_wait); end
         checks++; if (stall_cnt_o !== exp_cnt[31:0]) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", cyc, stall_cnt_o, exp_cnt); end
         hold = c.stl || c.frz;
         tick();
      end
      br = 1'b0;
      mem_ready = 1'b1;
      idle_id();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      br = 1'b0;
      mem_ready = 1'b1;
      idle_id();
      model_reset();
      test_reset();
      test_load_use();
      test_alu_fwd();
      test_mem_wait();
      test_branch();
      test_x0();
      test_reset_mid_freeze();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It tracks destination registers in flight in EX, MEM and WB through an internal scoreboard, and drives stall, flush, freeze and forwarding-select signals to the fetch, decode and execute stages. It also handles data-memory wait states and counts stall cycles for performance monitoring.

## Interface
- CNT_W, 32, width of the stall-cycle performance counter
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- id_valid_i  in  1  decode stage holds a real instruction
- id_rs1_i, id_rs2_i  in  5 each  decode source register addresses
- id_use_rs1_i, id_use_rs2_i  in  1 each  instruction actually reads rs1 / rs2
- id_rd_i  in  5  decode destination address
- id_reg_write_i  in  1  decode instruction writes rd
- id_mem_read_i  in  1  decode instruction is a LOAD
- id_mem_op_i  in  1  decode instruction is a LOAD or a STORE
- ex_branch_taken_i  in  1  branch or jump in EX redirects the PC
- mem_ready_i  in  1  data memory completes the access in MEM this cycle
- stall_o  out  1  hold the PC and the IF/ID register
- flush_id_o  out  1  clear the IF/ID register to a bubble
- flush_ex_o  out  1  load a bubble into the ID/EX register
- freeze_o  out  1  hold every pipeline register, including MEM/WB
- fwd_a_o, fwd_b_o  out  2 each  EX operand source: 00 = ID/EX value, 01 = EX/MEM result, 10 = WB data
- wb_byp1_o, wb_byp2_o  out  1 each  ID/EX captures WB write data instead of the regfile read for rs1 / rs2
- stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o or freeze_o high

## Operation
- Scoreboard: three slots, EX, MEM and WB. Each slot holds {valid, rd, reg_write, mem_read, mem_op, rs1, rs2, use_rs1, use_rs2}.
- A slot is a producer only when valid && reg_write && rd != 0. x0 never creates a hazard.
- FSM states:
  - RUN → MEM_WAIT when the MEM slot is valid, mem_op is set and mem_ready_i = 0.
  - MEM_WAIT → RUN on the first cycle with mem_ready_i = 1.
  - While the condition holds the FSM stays in MEM_WAIT. freeze_o = 1 in MEM_WAIT and also in the RUN cycle that detects the condition, since freeze_o is combinational.
- Slot advance on cycles with freeze_o = 0:
  - WB ← MEM, MEM ← EX.
  - EX ← bubble if stall_o, flush_ex_o or !id_valid_i; otherwise EX ← the ID fields.
- While freeze_o = 1, all slots hold their values.
- Load-use: stall_o = flush_ex_o = 1 when the EX slot is a producer with mem_read set and its rd equals a used ID source.
- Branch: ex_branch_taken_i = 1 gives flush_id_o = flush_ex_o = 1 and stall_o = 0. This suppresses any load-use stall, because the ID instruction is killed.
- Priority: freeze > branch flush > load-use stall. While frozen, stall_o, flush_id_o and flush_ex_o are 0. A branch held during a freeze acts in the first unfrozen cycle.
- Forwarding for the EX slot operands:
  - 01 if the MEM slot is a producer with rd matching and mem_read = 0.
  - else 10 if the WB slot is a producer with rd matching.
  - else 00.
  - An operand with use = 0 always gets 00.
- WB→ID bypass: wb_byp1_o = 1 when the WB slot is a producer, rd == id_rs1_i and id_use_rs1_i = 1. wb_byp2_o follows the same rule for rs2. This covers the regfile writing at the same edge the ID/EX register captures.
- Counter: stall_cnt_o increments on each cycle with stall_o or freeze_o high and saturates at all-ones.

## Timing
- Reset values: all slots invalid, FSM in RUN, stall_cnt_o = 0. All outputs are 0 while rst_i is high.
- All control outputs are combinational from the slots and the ID and memory inputs, and valid in the same cycle.
- Load-use penalty: exactly 1 cycle. Branch penalty: 2 bubbles.
- A reset mid-freeze or mid-stall returns to RUN with empty slots; no pending branch is retained.
- Simultaneous load-use and mem stall: freeze wins. Load-use is re-evaluated after the freeze lifts.

## Configuration
- HAZARD_FWD_EN defined: forwarding and the WB→ID bypass operate as described above.
- HAZARD_FWD_EN undefined:
  - fwd_a_o, fwd_b_o, wb_byp1_o and wb_byp2_o are tied to 0.
  - stall_o = flush_ex_o = 1 whenever any EX, MEM or WB producer matches a used ID source.
  - A dependent ALU pair therefore costs 3 cycles.

## Test plan
- lw x5 followed by add x6,x5,x1: 1 cycle with stall_o = flush_ex_o = 1, then add in EX with fwd_a_o = 10. stall_cnt_o = 1.
- add x5 followed by sub x7,x5,x5: no stall; fwd_a_o = fwd_b_o = 01 while sub is in EX.
- lw in MEM with mem_ready_i low for 3 cycles: freeze_o high for 3 cycles, slots unchanged, stall_cnt_o += 3. The FSM returns to RUN on ready.
- ex_branch_taken_i pulse while a load-use pair sits in EX/ID: flush_id_o = flush_ex_o = 1, stall_o = 0, and the EX slot becomes a bubble next cycle.
- add x0 followed by add x6,x0,x0: no stall, fwd 00, no bypass. Separately, rst_i asserted during MEM_WAIT clears all state and outputs immediately.
- Without HAZARD_FWD_EN: add x5 followed by add x6,x5 gives 3 stall cycles and fwd outputs always 00.
